// File: rtl/fft_power_spectrum_if.sv
// fft_power_spectrum_if: carries the FFT-side sample stream and the
// downstream averaged-bin stream for fft_power_spectrum.
// The slave modport is the power-spectrum block; the master modport is the
// environment around it (the FFT upstream and the consumer downstream).
interface fft_power_spectrum_if;
  logic               in_push;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               in_stall;
  logic               out_push_F;
  logic [3:0]         out_bin_F;
  logic [31:0]        out_power_F;
  logic               out_last_F;
  logic [3:0]         out_peak_bin_F;
  logic [31:0]        out_peak_power_F;
  logic               out_stall;

  modport slave (
    input  in_push, in_real, in_imag, out_stall,
    output in_stall, out_push_F, out_bin_F, out_power_F, out_last_F,
           out_peak_bin_F, out_peak_power_F
  );

  modport master (
    output in_push, in_real, in_imag, out_stall,
    input  in_stall, out_push_F, out_bin_F, out_power_F, out_last_F,
           out_peak_bin_F, out_peak_power_F
  );
endinterface

// File: rtl/fft_power_spectrum.sv
// fft_power_spectrum: squares each 16-point FFT bin, averages the power over
// 2^LOG2_AVG frames and streams the 16 averaged bins out, reporting the peak
// bin together with the final bin of each spectrum.
// Optional build macro FFT_PWR_BITREV_EN: input arrives in bit-reversed order,
// arrival k is stored as bin bitrev4(k) so the drain emits natural order.
module fft_power_spectrum #(
  parameter int LOG2_AVG = 2,
  parameter int NPTS     = 16
) (
  input  logic clk,
  input  logic reset,
  fft_power_spectrum_if.slave bus
);

  localparam int         AW         = 32 + LOG2_AVG;
  localparam logic [3:0] LAST_BIN   = 4'(NPTS - 1);
  localparam logic [4:0] LAST_FRAME = 5'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

  state_t state, next_state;

  logic [3:0] bin_cnt;
  logic [4:0] frame_cnt;
  logic       flush_cnt;
  logic [3:0] rd_cnt;
  logic       accept;
  logic [3:0] arrival_entry;

  logic               s1_valid;
  logic signed [15:0] s1_real;
  logic signed [15:0] s1_imag;
  logic [3:0]         s1_entry;
  logic               s1_first;

  logic signed [31:0] re_ext, im_ext, re_sq, im_sq;
  logic [31:0]        p_sum;

  logic        p_valid;
  logic [31:0] p_val;
  logic [3:0]  p_entry;
  logic        p_first;

  logic [AW-1:0] acc [16];
  logic [AW-1:0] acc_rd;
  logic [31:0]   rd_power;

  logic [3:0]  peak_bin;
  logic [31:0] peak_power;
  logic        peak_upd;
  logic [3:0]  cand_bin;
  logic [31:0] cand_power;

`ifdef FFT_PWR_BITREV_EN
  assign arrival_entry = {bin_cnt[0], bin_cnt[1], bin_cnt[2], bin_cnt[3]};
`else
  assign arrival_entry = bin_cnt;
`endif

  assign accept       = bus.in_push && (state == ACCUM);
  assign bus.in_stall = (state != ACCUM);

  assign re_ext = 32'(s1_real);
  assign im_ext = 32'(s1_imag);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign p_sum  = $unsigned(re_sq) + $unsigned(im_sq);

  assign acc_rd   = acc[rd_cnt];
  assign rd_power = 32'(acc_rd >> LOG2_AVG);

  assign peak_upd   = rd_power > peak_power;
  assign cand_bin   = peak_upd ? rd_cnt   : peak_bin;
  assign cand_power = peak_upd ? rd_power : peak_power;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= next_state;
  end

  // Next-state: leave ACCUM on the final sample, wait out the pipeline, drain
  always_comb begin
    next_state = state;
    case (state)
      ACCUM: if (accept && bin_cnt == LAST_BIN && frame_cnt == LAST_FRAME)
               next_state = FLUSH;
      FLUSH: if (flush_cnt) next_state = DRAIN;
      DRAIN: if (!bus.out_stall && rd_cnt == LAST_BIN) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // Bin/frame/flush/read counters
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt   <= '0;
      frame_cnt <= '0;
      flush_cnt <= 1'b0;
      rd_cnt    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          flush_cnt <= 1'b0;
          rd_cnt    <= '0;
          if (accept) begin
            bin_cnt <= bin_cnt + 4'd1;
            if (bin_cnt == LAST_BIN)
              frame_cnt <= (frame_cnt == LAST_FRAME) ? 5'd0 : frame_cnt + 5'd1;
          end
        end
        FLUSH: flush_cnt <= 1'b1;
        DRAIN: begin
          if (!bus.out_stall) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_cnt == LAST_BIN) begin
              bin_cnt   <= '0;
              frame_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Capture accepted samples with their target entry and first-frame flag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_real  <= '0;
      s1_imag  <= '0;
      s1_entry <= '0;
      s1_first <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_real  <= bus.in_real;
        s1_imag  <= bus.in_imag;
        s1_entry <= arrival_entry;
        s1_first <= (frame_cnt == 5'd0);
      end
    end
  end

  // Register the squared magnitude
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_val   <= '0;
      p_entry <= '0;
      p_first <= 1'b0;
    end else begin
      p_valid <= s1_valid;
      p_val   <= p_sum;
      p_entry <= s1_entry;
      p_first <= s1_first;
    end
  end

  // Accumulator: first frame overwrites, later frames add
  always_ff @(posedge clk) begin
    if (p_valid)
      acc[p_entry] <= p_first ? AW'(p_val) : acc[p_entry] + AW'(p_val);
  end

  // Output pushes and running peak tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_push_F       <= 1'b0;
      bus.out_bin_F        <= '0;
      bus.out_power_F      <= '0;
      bus.out_last_F       <= 1'b0;
      bus.out_peak_bin_F   <= '0;
      bus.out_peak_power_F <= '0;
      peak_bin             <= '0;
      peak_power           <= '0;
    end else begin
      bus.out_push_F       <= 1'b0;
      bus.out_last_F       <= 1'b0;
      bus.out_peak_bin_F   <= '0;
      bus.out_peak_power_F <= '0;
      if (state == FLUSH) begin
        peak_bin   <= '0;
        peak_power <= '0;
      end
      if (state == DRAIN && !bus.out_stall) begin
        bus.out_push_F  <= 1'b1;
        bus.out_bin_F   <= rd_cnt;
        bus.out_power_F <= rd_power;
        peak_bin        <= cand_bin;
        peak_power      <= cand_power;
        if (rd_cnt == LAST_BIN) begin
          bus.out_last_F       <= 1'b1;
          bus.out_peak_bin_F   <= cand_bin;
          bus.out_peak_power_F <= cand_power;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_power_spectrum.sv
// tb_fft_power_spectrum: directed checks of fft_power_spectrum with
// LOG2_AVG = 2 (four frames averaged per spectrum). Expected bin powers come
// from hand values and a small accumulation model of the input frames.
// Honours FFT_PWR_BITREV_EN when the design is built with it.
module tb_fft_power_spectrum;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fft_power_spectrum_if ifc();

  fft_power_spectrum #(.LOG2_AVG(2), .NPTS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] frame_re [16];
  logic signed [15:0] frame_im [16];
  longint             model_acc [16];
  logic [31:0]        cap_power [16];
  logic [3:0]         cap_peak_bin;
  logic [31:0]        cap_peak_power;

  // Abort a hung run with a visible failure
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] entry_of(input int k);
    logic [3:0] v;
    v = 4'(k);
`ifdef FFT_PWR_BITREV_EN
    return {v[0], v[1], v[2], v[3]};
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      frame_re[i] = '0;
      frame_im[i] = '0;
    end
  endtask

  // Stream one frame of 16 samples; the first frame of a spectrum resets the model
  task automatic applyStimulus(input bit first_frame);
    int guard;
    if (first_frame)
      for (int i = 0; i < 16; i++) model_acc[i] = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      guard = 0;
      while (ifc.in_stall && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) check("accept_wait", 32'(ifc.in_stall), 32'd0);
      ifc.in_push = 1'b1;
      ifc.in_real = frame_re[k];
      ifc.in_imag = frame_im[k];
      model_acc[entry_of(k)] += longint'(frame_re[k]) * longint'(frame_re[k])
                              + longint'(frame_im[k]) * longint'(frame_im[k]);
    end
    @(negedge clk);
    ifc.in_push = 1'b0;
  endtask

  // Collect pushes, checking order, power, last flag and peak on the 16th
  task automatic checkOutput(input bit stall_mode, input bit junk_push, input int stop_after);
    logic [31:0] exp_p;
    logic [31:0] pk_pw;
    logic [3:0]  pk_bin;
    int got;
    int cycles;
    pk_pw  = '0;
    pk_bin = '0;
    got    = 0;
    cycles = 0;
    if (junk_push) begin
      ifc.in_push = 1'b1;
      ifc.in_real = 16'sd1000;
      ifc.in_imag = -16'sd1000;
    end
    while (got < stop_after && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (ifc.out_push_F) begin
        exp_p = 32'(model_acc[got] >> 2);
        if (got == 0 && !stall_mode) check("first_push_latency", 32'(cycles), 32'd3);
        if (stall_mode) check("stall_respected", 32'(ifc.out_stall), 32'd0);
        check("bin_order", 32'(ifc.out_bin_F), 32'(got));
        check("power", ifc.out_power_F, exp_p);
        check("last_flag", 32'(ifc.out_last_F), (got == 15) ? 32'd1 : 32'd0);
        if (exp_p > pk_pw) begin
          pk_pw  = exp_p;
          pk_bin = 4'(got);
        end
        cap_power[got] = ifc.out_power_F;
        if (got == 15) begin
          check("peak_bin", 32'(ifc.out_peak_bin_F), 32'(pk_bin));
          check("peak_power", ifc.out_peak_power_F, pk_pw);
          cap_peak_bin   = ifc.out_peak_bin_F;
          cap_peak_power = ifc.out_peak_power_F;
        end
        got++;
        if (got == 16) ifc.in_push = 1'b0;
      end
      if (stall_mode) ifc.out_stall = ~ifc.out_stall;
    end
    ifc.out_stall = 1'b0;
    if (got < stop_after) check("push_count", 32'(got), 32'(stop_after));
  endtask

  task automatic expect_quiet(input int n);
    int pushes;
    pushes = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifc.out_push_F) pushes++;
    end
    check("extra_push", 32'(pushes), 32'd0);
  endtask

  initial begin
    logic [3:0] tie_bin;
    reset         = 1'b1;
    ifc.in_push   = 1'b0;
    ifc.in_real   = '0;
    ifc.in_imag   = '0;
    ifc.out_stall = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check("rst_push", 32'(ifc.out_push_F), 32'd0);
    check("rst_bin", 32'(ifc.out_bin_F), 32'd0);
    check("rst_power", ifc.out_power_F, 32'd0);
    check("rst_last", 32'(ifc.out_last_F), 32'd0);
    check("rst_peak_bin", 32'(ifc.out_peak_bin_F), 32'd0);
    check("rst_peak_power", ifc.out_peak_power_F, 32'd0);
    check("rst_in_stall", 32'(ifc.in_stall), 32'd0);
    reset = 1'b0;

    $display("[TB] single tone at bin 3");
    clear_frame();
    frame_re[3] = 16'sd100;
    frame_im[3] = -16'sd200;
    for (int f = 0; f < 4; f++) applyStimulus(f == 0);
    checkOutput(1'b0, 1'b0, 16);
    check("tone_power", cap_power[entry_of(3)], 32'd50000);
    check("tone_zero_bin", cap_power[entry_of(0)], 32'd0);
    check("tone_peak_bin", 32'(cap_peak_bin), 32'(entry_of(3)));
    check("tone_peak_power", cap_peak_power, 32'd50000);
    expect_quiet(5);

    $display("[TB] averaging with full-scale bin 7");
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        frame_re[i] = 16'sd3;
        frame_im[i] = 16'sd4;
      end
      frame_re[7] = -16'sd32768;
      frame_im[7] = -16'sd32768;
      frame_re[0] = 16'(2 * f);
      frame_im[0] = 16'sd0;
      applyStimulus(f == 0);
    end
    checkOutput(1'b0, 1'b0, 16);
    check("avg_flat", cap_power[entry_of(5)], 32'd25);
    check("avg_full_scale", cap_power[entry_of(7)], 32'h8000_0000);
    check("avg_varying", cap_power[entry_of(0)], 32'd14);
    check("avg_peak_bin", 32'(cap_peak_bin), 32'(entry_of(7)));
    check("avg_peak_power", cap_peak_power, 32'h8000_0000);

    $display("[TB] stall toggling with in_push held during drain");
    clear_frame();
    for (int i = 0; i < 16; i++) frame_re[i] = 16'(i + 1);
    for (int f = 0; f < 4; f++) applyStimulus(f == 0);
    checkOutput(1'b1, 1'b1, 16);
    check("ramp_bin15", cap_power[entry_of(15)], 32'd256);
    expect_quiet(5);

    $display("[TB] tie between bins 2 and 9");
    clear_frame();
    frame_re[2] = 16'sd10;
    frame_re[9] = 16'sd10;
    for (int f = 0; f < 4; f++) applyStimulus(f == 0);
    checkOutput(1'b0, 1'b0, 16);
    tie_bin = (entry_of(2) < entry_of(9)) ? entry_of(2) : entry_of(9);
    check("tie_peak_bin", 32'(cap_peak_bin), 32'(tie_bin));
    check("tie_peak_power", cap_peak_power, 32'd100);

    $display("[TB] reset during drain");
    clear_frame();
    for (int i = 0; i < 16; i++) frame_re[i] = 16'(10 * i);
    for (int f = 0; f < 4; f++) applyStimulus(f == 0);
    checkOutput(1'b0, 1'b0, 5);
    reset = 1'b1;
    @(negedge clk);
    check("abort_push", 32'(ifc.out_push_F), 32'd0);
    check("abort_power", ifc.out_power_F, 32'd0);
    check("abort_bin", 32'(ifc.out_bin_F), 32'd0);
    check("abort_in_stall", 32'(ifc.in_stall), 32'd0);
    reset = 1'b0;
    expect_quiet(20);
    clear_frame();
    frame_re[5] = 16'sd7;
    for (int f = 0; f < 4; f++) applyStimulus(f == 0);
    checkOutput(1'b0, 1'b0, 16);
    check("fresh_bin5", cap_power[entry_of(5)], 32'd49);
    check("fresh_bin4", cap_power[entry_of(4)], 32'd0);

    $display("[TB] arrival 1 carries a tone");
    clear_frame();
    frame_re[1] = 16'sd5;
    for (int f = 0; f < 4; f++) applyStimulus(f == 0);
    checkOutput(1'b0, 1'b0, 16);
`ifdef FFT_PWR_BITREV_EN
    check("order_power", cap_power[8], 32'd25);
    check("order_peak_bin", 32'(cap_peak_bin), 32'd8);
`else
    check("order_power", cap_power[1], 32'd25);
    check("order_peak_bin", 32'(cap_peak_bin), 32'd1);
`endif
    expect_quiet(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_power_spectrum.md
Name: fft_power_spectrum

Overview:
Downstream consumer of the 16-point FFT output stream. Computes per-bin power |X|^2 and averages it over 2^LOG2_AVG consecutive frames. Streams out 16 averaged bins with a push/stall handshake and reports the peak bin on the last push. The upstream FFT's out_push/out_real/out_imag drive in_push/in_real/in_imag, and this block's in_stall drives the FFT's out_stall.

Parameters:
LOG2_AVG, 2, log2 of frames averaged per output spectrum (0..4); 0 = no averaging
NPTS, 16, bins per frame; fixed at 16, and the bin counter is 4 bits

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high
in_push  input  1  input sample valid; accepted when in_push && !in_stall
in_real  input  16  signed two's-complement real part
in_imag  input  16  signed two's-complement imaginary part
in_stall  output  1  back-pressure to the FFT
out_push_F  output  1  one-cycle push of one output bin
out_bin_F  output  4  bin index of the pushed value
out_power_F  output  32  unsigned averaged power
out_last_F  output  1  high with the push of the final bin of a spectrum
out_peak_bin_F  output  4  index of the maximum-power bin; valid only when out_last_F
out_peak_power_F  output  32  power of that bin; valid only when out_last_F
out_stall  input  1  downstream back-pressure

Behaviour:
- Reset state: all outputs 0; state ACCUM; bin_cnt = 0; frame_cnt = 0; peak registers 0. Reset mid-DRAIN aborts the spectrum with no further pushes.
- Power: p = re*re + im*im, each product signed 16x16. Result held as 32-bit unsigned. Maximum is 2^31 at (-32768,-32768); no saturation needed.
- Accumulator: 16 entries x (32+LOG2_AVG) bits.
  - Frame 0 writes p, overwriting the entry.
  - Frames 1..N-1 write entry+p.
- Pipeline: sample accepted at cycle t; p registered at t+1; accumulator written at t+2.
  - Each bin is touched once per frame, so there is no read-modify-write hazard.
- States:
  - ACCUM: in_stall = 0. Each accepted sample increments bin_cnt, which wraps 15->0. On the wrap, frame_cnt increments.
  - ACCUM -> FLUSH: when the bin-15 sample of frame 2^LOG2_AVG-1 is accepted.
  - FLUSH: in_stall = 1 for 2 cycles until the last accumulator write lands, then -> DRAIN.
  - DRAIN: in_stall = 1; rd_cnt runs 0..15.
    - Each cycle with out_stall = 0: out_push_F <= 1, out_bin_F/out_power_F <= bin rd_cnt, with power = entry >> LOG2_AVG (truncating); rd_cnt increments.
    - Each cycle with out_stall = 1: out_push_F <= 0 and rd_cnt holds.
  - DRAIN -> ACCUM: after the rd_cnt = 15 push. frame_cnt and bin_cnt clear to 0; in_stall drops the next cycle.
- Peak: updated as bins are pushed using strict greater-than, so ties keep the lowest pushed index. Peak is cleared at DRAIN entry.
  - out_last_F is high with the 16th push. That push also presents the peak, including the 16th bin's own value.
- in_push while in_stall = 1: the sample is ignored and no counters move.
- Output latency: first push occurs 1 cycle after DRAIN entry, provided out_stall = 0.
- Throughput: one sample per cycle in ACCUM. One spectrum per (16*2^LOG2_AVG + 2 + 16) cycles when unstalled.

Optional Feature:
FFT_PWR_BITREV_EN:
- Defined: input order is treated as bit-reversed (arrival k is bin bitrev4(k)). Arrival k writes accumulator entry bitrev4(k), so DRAIN emits natural order 0..15 with out_bin_F = natural index.
- Undefined: entry = arrival index, and out_bin_F = arrival index.
- Peak tie-break in both cases: lowest emitted position.

Test Plan:
1. LOG2_AVG=0. One frame with bin 3 = (100,-200) and all other bins = 0 -> 16 pushes; bin 3 power 50000, others 0; out_last_F on 16th push with peak_bin 3, peak_power 50000.
2. LOG2_AVG=2. Four frames with every bin = (3,4) -> every out_power_F = 25. In frames with bin 7 = (-32768,-32768), bin 7 sums to 4*2^31, so out_power_F = 2^31 with no overflow.
3. Toggle out_stall every other cycle during DRAIN -> exactly 16 pushes, bins 0..15 in order, none duplicated or skipped. in_push held high during DRAIN is ignored; the first post-DRAIN sample lands in bin 0 of frame 0.
4. Tie: bins 2 and 9 both = (10,0), others = 0 -> peak_bin 2, peak_power 100.
5. Assert reset during DRAIN at rd_cnt = 5 -> outputs 0 the next cycle; no further pushes; the next frame is accumulated from bin 0, frame 0, with a fresh overwrite.
6. FFT_PWR_BITREV_EN defined. Arrival index 1 carries (5,0), others 0 -> push with out_bin_F = 8 shows power 25; peak_bin 8.
